router_a_arb: RTL and testbench

ROUTER_A_ARB -- requirements
Module: router_a_arb

---
 rtl/router_a_arb_if.sv | 35 +++
 rtl/router_a_arb.sv | 120 ++++++++++++
 tb/tb_router_a_arb.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/router_a_arb_if.sv
// rtl/router_a_arb_if.sv - bundle of external write, ALU writeback and register-file signals
interface router_a_arb_if #(
    parameter int W     = 24,
    parameter int ADDRW = 5,
    parameter int DEPTH = 4
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic [W-1:0]     DATA_IN;
    logic [ADDRW-1:0] DIR;
    logic             WRITE;
    logic             BUSY;
    logic [W-1:0]     result;
    logic [ADDRW-1:0] ctl_a;
    logic             READY;
    logic [ADDRW-1:0] ctl_b;
    logic             sel_dirb;
    logic             CLR_OVF;
    logic [W-1:0]     data;
    logic [ADDRW-1:0] dira;
    logic [ADDRW-1:0] dirb;
    logic             write;
    logic [LW-1:0]    LEVEL;
    logic             OVF;

    modport slave (
        input  DATA_IN, DIR, WRITE, result, ctl_a, READY, ctl_b, sel_dirb, CLR_OVF,
        output BUSY, data, dira, dirb, write, LEVEL, OVF
    );

    modport master (
        output DATA_IN, DIR, WRITE, result, ctl_a, READY, ctl_b, sel_dirb, CLR_OVF,
        input  BUSY, data, dira, dirb, write, LEVEL, OVF
    );
endinterface

// File: rtl/router_a_arb.sv
// rtl/router_a_arb.sv - register-file write arbiter: ALU writeback over queued/bypassed external writes
module router_a_arb #(
    parameter int W     = 24,
    parameter int ADDRW = 5,
    parameter int DEPTH = 4
) (
    input  logic         CLK,
    input  logic         RST,
    router_a_arb_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;

    logic [W+ADDRW-1:0] mem [DEPTH];
    logic [PW-1:0]      rd_ptr;
    logic [PW-1:0]      wr_ptr;
    logic [LW-1:0]      level;

    logic               busy;
    logic               empty;
    logic               accept;
    logic               pop;
    logic               bypass;
    logic               push;
    logic [W-1:0]       head_data;
    logic [ADDRW-1:0]   head_addr;

    logic [W-1:0]       data_q;
    logic [ADDRW-1:0]   dira_q;
    logic [ADDRW-1:0]   dirb_q;
    logic               write_q;
    logic               ovf_q;

    // Arbitration decode: ALU first, then queued entries, then same-cycle bypass.
    // Full is judged on current occupancy only, so a pop never frees a slot this cycle.
    always_comb begin
        busy   = (level == LW'(DEPTH));
        empty  = (level == '0);
        accept = bus.WRITE && !busy;
        pop    = !bus.READY && !empty;
        bypass = !bus.READY && empty && accept;
        push   = accept && !bypass;
        {head_data, head_addr} = mem[rd_ptr];
    end

    // FIFO storage is not reset; occupancy alone decides whether contents are valid.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr] <= {bus.DATA_IN, bus.DIR};
        end
    end

    // Pointers wrap naturally at DEPTH (power of two); level tracks push minus pop.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Registered register-file write port; idle cycles hold data/dira and drop the strobe.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            data_q  <= '0;
            dira_q  <= '0;
            write_q <= 1'b0;
        end else if (bus.READY) begin
            data_q  <= bus.result;
            dira_q  <= bus.ctl_a;
            write_q <= 1'b1;
        end else if (pop) begin
            data_q  <= head_data;
            dira_q  <= head_addr;
            write_q <= 1'b1;
        end else if (bypass) begin
            data_q  <= bus.DATA_IN;
            dira_q  <= bus.DIR;
            write_q <= 1'b1;
        end else begin
            write_q <= 1'b0;
        end
    end

    // Read address follows its selected source every cycle, regardless of arbitration.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            dirb_q <= '0;
        end else begin
            dirb_q <= bus.sel_dirb ? bus.DIR : bus.ctl_b;
        end
    end

    // Sticky overflow: a dropped write sets it and beats a simultaneous clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ovf_q <= 1'b0;
        end else if (bus.WRITE && busy) begin
            ovf_q <= 1'b1;
        end else if (bus.CLR_OVF) begin
            ovf_q <= 1'b0;
        end
    end

    assign bus.BUSY  = busy;
    assign bus.LEVEL = level;
    assign bus.data  = data_q;
    assign bus.dira  = dira_q;
    assign bus.dirb  = dirb_q;
    assign bus.write = write_q;
    assign bus.OVF   = ovf_q;
endmodule

// File: tb/tb_router_a_arb.sv
// tb/tb_router_a_arb.sv - self-checking bench for router_a_arb
module tb_router_a_arb;
    localparam int DEPTH = 4;

    logic clk;
    logic rst;

    router_a_arb_if #(.W(24), .ADDRW(5), .DEPTH(DEPTH)) bus ();

    router_a_arb #(.W(24), .ADDRW(5), .DEPTH(DEPTH)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [23:0] res;
        logic [4:0]  ca;
        logic        wr;
        logic [23:0] din;
        logic [4:0]  dir;
        logic        sel;
        logic [4:0]  cb;
        logic        e_write;
        logic [23:0] e_data;
        logic [4:0]  e_dira;
        logic [4:0]  e_dirb;
        logic [2:0]  e_level;
    } vec_t;

    vec_t vt [5];

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a queue of pending external writes plus the visible outputs.
    logic [28:0] q [$];
    logic [23:0] m_data;
    logic [4:0]  m_dira;
    logic [4:0]  m_dirb;
    logic        m_write;
    logic        m_ovf;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_data  = '0;
        m_dira  = '0;
        m_dirb  = '0;
        m_write = 1'b0;
        m_ovf   = 1'b0;
    endtask

    task automatic set_in(input logic rdy, input logic [23:0] res, input logic [4:0] ca,
                          input logic wr, input logic [23:0] din, input logic [4:0] dir,
                          input logic sel, input logic [4:0] cb, input logic clr);
        bus.READY    = rdy;
        bus.result   = res;
        bus.ctl_a    = ca;
        bus.WRITE    = wr;
        bus.DATA_IN  = din;
        bus.DIR      = dir;
        bus.sel_dirb = sel;
        bus.ctl_b    = cb;
        bus.CLR_OVF  = clr;
    endtask

    task automatic set_idle();
        set_in(1'b0, 24'h0, 5'h0, 1'b0, 24'h0, 5'h0, 1'b0, 5'h0, 1'b0);
    endtask

    // One clock: predict from the inputs and model state, clock, then compare every output.
    task automatic tick();
        logic        full;
        logic        acc;
        logic [23:0] n_data;
        logic [4:0]  n_dira;
        logic        n_write;
        logic [28:0] head;
        #1;
        full = (q.size() == DEPTH);
        chk("busy_pre", 32'(bus.BUSY), 32'(full));
        acc     = bus.WRITE && !full;
        n_data  = m_data;
        n_dira  = m_dira;
        n_write = 1'b0;
        if (bus.READY) begin
            n_data  = bus.result;
            n_dira  = bus.ctl_a;
            n_write = 1'b1;
            if (acc) q.push_back({bus.DATA_IN, bus.DIR});
        end else if (q.size() != 0) begin
            head    = q.pop_front();
            n_data  = head[28:5];
            n_dira  = head[4:0];
            n_write = 1'b1;
            if (acc) q.push_back({bus.DATA_IN, bus.DIR});
        end else if (acc) begin
            n_data  = bus.DATA_IN;
            n_dira  = bus.DIR;
            n_write = 1'b1;
        end
        if (bus.WRITE && full)  m_ovf = 1'b1;
        else if (bus.CLR_OVF)   m_ovf = 1'b0;
        m_dirb = bus.sel_dirb ? bus.DIR : bus.ctl_b;
        @(posedge clk);
        #1;
        m_data  = n_data;
        m_dira  = n_dira;
        m_write = n_write;
        chk("m_write", 32'(bus.write), 32'(m_write));
        if (m_write) begin
            chk("m_data", 32'(bus.data), 32'(m_data));
            chk("m_dira", 32'(bus.dira), 32'(m_dira));
        end
        chk("m_dirb",  32'(bus.dirb),  32'(m_dirb));
        chk("m_level", 32'(bus.LEVEL), 32'(q.size()));
        chk("m_ovf",   32'(bus.OVF),   32'(m_ovf));
    endtask

    initial begin
        logic [23:0] seen_d [$];
        logic [4:0]  seen_a [$];
        int          max_lvl;

        vt[0] = '{1'b0, 24'h0, 5'h00, 1'b1, 24'h123456, 5'h12, 1'b0, 5'h1C,
                  1'b1, 24'h123456, 5'h12, 5'h1C, 3'd0};
        vt[1] = '{1'b1, 24'hC0FFEE, 5'h03, 1'b1, 24'h123456, 5'h12, 1'b1, 5'h1C,
                  1'b1, 24'hC0FFEE, 5'h03, 5'h12, 3'd1};
        vt[2] = '{1'b0, 24'h0, 5'h00, 1'b0, 24'h0, 5'h00, 1'b0, 5'h1C,
                  1'b1, 24'h123456, 5'h12, 5'h1C, 3'd0};
        vt[3] = '{1'b0, 24'h0, 5'h00, 1'b0, 24'h0, 5'h12, 1'b1, 5'h1C,
                  1'b0, 24'h123456, 5'h12, 5'h12, 3'd0};
        vt[4] = '{1'b0, 24'h0, 5'h00, 1'b0, 24'h0, 5'h12, 1'b0, 5'h1C,
                  1'b0, 24'h123456, 5'h12, 5'h1C, 3'd0};

        rst = 1'b1;
        set_idle();
        model_reset();
        #2;
        chk("rst_write", 32'(bus.write), 32'h0);
        chk("rst_data",  32'(bus.data),  32'h0);
        chk("rst_dira",  32'(bus.dira),  32'h0);
        chk("rst_dirb",  32'(bus.dirb),  32'h0);
        chk("rst_level", 32'(bus.LEVEL), 32'h0);
        chk("rst_ovf",   32'(bus.OVF),   32'h0);
        chk("rst_busy",  32'(bus.BUSY),  32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Bypass, contention, idle hold and dirb select from the vector table.
        for (int i = 0; i < 5; i++) begin
            set_in(vt[i].rdy, vt[i].res, vt[i].ca, vt[i].wr, vt[i].din, vt[i].dir,
                   vt[i].sel, vt[i].cb, 1'b0);
            tick();
            chk($sformatf("vec%0d_write", i), 32'(bus.write), 32'(vt[i].e_write));
            chk($sformatf("vec%0d_data",  i), 32'(bus.data),  32'(vt[i].e_data));
            chk($sformatf("vec%0d_dira",  i), 32'(bus.dira),  32'(vt[i].e_dira));
            chk($sformatf("vec%0d_dirb",  i), 32'(bus.dirb),  32'(vt[i].e_dirb));
            chk($sformatf("vec%0d_level", i), 32'(bus.LEVEL), 32'(vt[i].e_level));
        end

        // Fill under continuous READY, overflow on the fifth, then drain in order.
        for (int n = 1; n <= 5; n++) begin
            set_in(1'b1, 24'hA00000 + 24'(n), 5'(n), 1'b1, 24'hB00000 + 24'(n), 5'(n + 8),
                   1'b0, 5'h0, 1'b0);
            tick();
            chk("fill_level", 32'(bus.LEVEL), (n < 4) ? 32'(n) : 32'd4);
            chk("fill_alu",   32'(bus.data),  32'hA00000 + 32'(n));
        end
        chk("fill_busy", 32'(bus.BUSY), 32'h1);
        chk("fill_ovf",  32'(bus.OVF),  32'h1);
        for (int k = 1; k <= 4; k++) begin
            set_idle();
            tick();
            chk("drain_write", 32'(bus.write), 32'h1);
            chk("drain_data",  32'(bus.data),  32'hB00000 + 32'(k));
            chk("drain_dira",  32'(bus.dira),  32'(k + 8));
            chk("drain_level", 32'(bus.LEVEL), 32'(4 - k));
        end
        chk("drain_ovf_sticky", 32'(bus.OVF), 32'h1);
        set_in(1'b0, 24'h0, 5'h0, 1'b0, 24'h0, 5'h0, 1'b0, 5'h0, 1'b1);
        tick();
        chk("clr_ovf", 32'(bus.OVF), 32'h0);

        // Wrap: ten writes through the FIFO with occupancy cycling up to 3.
        max_lvl = 0;
        for (int c = 0; c < 14; c++) begin
            if (c < 10)
                set_in(c < 3, 24'h111111, 5'h1F, 1'b1, 24'hC00000 + 24'(c), 5'(c), 1'b0, 5'h0, 1'b0);
            else
                set_idle();
            tick();
            if (int'(bus.LEVEL) > max_lvl) max_lvl = int'(bus.LEVEL);
            if (bus.write && bus.data[23:20] == 4'hC) begin
                seen_d.push_back(bus.data);
                seen_a.push_back(bus.dira);
            end
        end
        chk("wrap_count", 32'(seen_d.size()), 32'd10);
        chk("wrap_maxlvl", 32'(max_lvl), 32'd3);
        for (int i = 0; i < 10 && i < seen_d.size(); i++) begin
            chk("wrap_data", 32'(seen_d[i]), 32'hC00000 + 32'(i));
            chk("wrap_dira", 32'(seen_a[i]), 32'(i));
        end

        // Asynchronous reset with two queued entries and overflow set.
        for (int n = 0; n < 5; n++) begin
            set_in(1'b1, 24'h222222, 5'h02, 1'b1, 24'hD00000 + 24'(n), 5'(n), 1'b0, 5'h0, 1'b0);
            tick();
        end
        set_idle();
        tick();
        tick();
        chk("pre_rst_level", 32'(bus.LEVEL), 32'd2);
        chk("pre_rst_ovf",   32'(bus.OVF),   32'h1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_write", 32'(bus.write), 32'h0);
        chk("arst_data",  32'(bus.data),  32'h0);
        chk("arst_dira",  32'(bus.dira),  32'h0);
        chk("arst_level", 32'(bus.LEVEL), 32'h0);
        chk("arst_ovf",   32'(bus.OVF),   32'h0);
        chk("arst_busy",  32'(bus.BUSY),  32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("post_rst_write", 32'(bus.write), 32'h0);
        end

        // Randomized traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            set_in($urandom_range(0, 9) < 4, 24'($urandom), 5'($urandom),
                   $urandom_range(0, 9) < 6, 24'($urandom), 5'($urandom),
                   1'($urandom), 5'($urandom), $urandom_range(0, 15) == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
